shiftreg_piso_stream: RTL
=========================

// Module: shiftreg_piso_stream
// PURPOSE
//  Parametrised parallel-in/serial-out shifter with a valid/ready input stream and framing outputs.
//  Has a one-word holding buffer, so consecutive words serialise with no gap bit.
//  Sits between word-wide producers and single-bit serial links/encoders in the design.
// PARAMETERS
//  WIDTH       16  bits per word; legal range >= 2
//  MSB_FIRST   1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//  IDLE_LEVEL  0   value driven on dout whenever out_valid=0
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      reset; asynchronous assert, active-low (0 = reset)
//  flush       in   1      synchronous abort of current and buffered word
//  in_valid    in   1      din is valid
//  in_ready    out  1      block can accept din this cycle
//  din         in   WIDTH  parallel word
//  dout        out  1      serial bit
//  out_valid   out  1      dout carries a data bit
//  out_first   out  1      dout is first bit of a word
//  out_last    out  1      dout is last bit of a word
//  busy        out  1      word held or being shifted
// BEHAVIOUR
//  - Reset (rst=0, async): hold_valid=0, state IDLE, sreg=0, cnt=0.
//    Outputs: dout=IDLE_LEVEL, out_valid=0, out_first=0, out_last=0, busy=0, in_ready=1.
//  - in_ready = !hold_valid (pure register decode; no combinational path from in_valid).
//    Accept when in_valid && in_ready at a rising edge: din -> hold, hold_valid=1.
//  - States: IDLE (out_valid=0) and SHIFT (out_valid=1).
//    Load happens at an edge where hold_valid=1 and (state==IDLE or out_last=1).
//    On load: hold -> sreg, cnt=0, state=SHIFT, hold_valid=0.
//  - Latency: word accepted at edge E0 appears as first bit on dout after edge E1 (1 cycle).
//  - In SHIFT, each edge emits the next bit and cnt++.
//    dout = sreg[WIDTH-1] if MSB_FIRST, else sreg[0]; shift left/right respectively, 0 filled.
//  - out_first = (state==SHIFT && cnt==0); out_last = (state==SHIFT && cnt==WIDTH-1).
//  - At out_last with hold empty: state -> IDLE. With hold full: load, giving gapless output.
//    WIDTH>=2 guarantees that a producer answering in_ready within 1 cycle never starves.
//  - cnt width = $clog2(WIDTH); cnt never exceeds WIDTH-1; no wrap inside a word.
//  - Simultaneous accept and load in the same edge: the load takes the old hold.
//    The new din enters hold and hold_valid stays 1. Possible only when in_ready=1 (hold empty).
//    In that case the load does not occur, so there is no conflict.
//  - flush=1 at an edge: hold_valid=0, state=IDLE, cnt=0. Outputs go idle the next cycle.
//    A word offered in the same cycle as flush is dropped (in_ready still reads 1). flush beats load.
//  - busy = hold_valid || (state==SHIFT).
//  - Reset asserted mid-word: word lost, outputs go to reset values immediately (no clock needed).
// STRUCTURE
//  - Shared package shiftreg_pkg:
//    typedef enum logic {PISO_IDLE, PISO_SHIFT} piso_state_t; localparam PISO_MIN_WIDTH = 2.
//  - Single module; no sub-module needed (holding register + shifter + counter are small).
//  - Elaboration-time assertion: WIDTH >= PISO_MIN_WIDTH.
// TESTING (WIDTH=16 unless noted)
//  - MSB_FIRST=1, send 16'hA5C3 -> dout 1010_0101_1100_0011 over 16 valid cycles.
//    out_first on cycle 1 only, out_last on cycle 16 only, then out_valid=0, dout=IDLE_LEVEL.
//  - Back-to-back 16'hFFFF, 16'h0000, in_valid held high -> 32 consecutive out_valid cycles.
//    16 ones then 16 zeros; each word accepted exactly once.
//  - MSB_FIRST=0, send 16'h0001 -> first bit 1, then 15 zeros; out_last on 16th bit.
//  - Backpressure: 3 words with in_valid always 1 -> in_ready low while hold full.
//    Output is exactly 48 bits in order; no word duplicated or dropped.
//  - flush after 5 bits of 16'hFFFF with 2nd word held -> next cycle out_valid=0, busy=0, in_ready=1.
//    Nothing further emitted.
//  - rst=0 asynchronously mid-word, between clock edges -> all outputs at reset values before the next edge.
//    After release, 16'h8001 serialises normally.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared types and limits for the shift-register family of blocks.
package shiftreg_pkg;

  typedef enum logic {PISO_IDLE, PISO_SHIFT} piso_state_t;

  localparam int PISO_MIN_WIDTH = 2;

endpackage

// File: rtl/shiftreg_piso_stream.sv
// Parallel-in/serial-out shifter with a valid/ready word input, a one-word holding
// buffer for gapless back-to-back words, and first/last framing on the serial side.
module shiftreg_piso_stream
  import shiftreg_pkg::*;
#(
  parameter int   WIDTH      = 16,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < PISO_MIN_WIDTH) begin : g_width_check
    $error("shiftreg_piso_stream: WIDTH must be at least %0d", PISO_MIN_WIDTH);
  end

  piso_state_t      state, state_next;
  logic [WIDTH-1:0] hold, hold_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic             hold_valid, hold_valid_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             accept;
  logic             load;

  // Every output is a decode of registered state, so none depends on in_valid.
  assign in_ready  = !hold_valid;
  assign out_valid = (state == PISO_SHIFT);
  assign out_first = out_valid && (cnt == '0);
  assign out_last  = out_valid && (cnt == CNT_LAST);
  assign busy      = hold_valid || out_valid;
  assign dout      = out_valid ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_LEVEL;

  // Accept needs an empty hold and load needs a full one, so they never collide.
  assign accept = in_valid && in_ready;
  assign load   = hold_valid && (!out_valid || out_last);

  always_comb begin
    state_next      = state;
    hold_next       = hold;
    hold_valid_next = hold_valid;
    sreg_next       = sreg;
    cnt_next        = cnt;

    if (flush) begin
      state_next      = PISO_IDLE;
      hold_valid_next = 1'b0;
      cnt_next        = '0;
    end else begin
      if (accept) begin
        hold_next       = din;
        hold_valid_next = 1'b1;
      end

      // Reloading on the last bit is what keeps consecutive words gapless.
      if (load) begin
        sreg_next       = hold;
        cnt_next        = '0;
        state_next      = PISO_SHIFT;
        hold_valid_next = 1'b0;
      end else if (out_valid) begin
        if (out_last) begin
          state_next = PISO_IDLE;
          cnt_next   = '0;
        end else begin
          sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
          cnt_next  = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PISO_IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      sreg       <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_next;
      hold       <= hold_next;
      hold_valid <= hold_valid_next;
      sreg       <= sreg_next;
      cnt        <= cnt_next;
    end
  end

endmodule
